// File: rtl/pcie_trn_pkg.sv
// Shared types and constants for the PCIe TRN transmit arbiter.
//   arb_state_t : arbiter FSM states (IDLE, PKT, CFG)
//   TRN_DW      : TRN data path width in bits
//   TBUF_W      : width of the trn_tbuf_av free-buffer count
package pcie_trn_pkg;

    localparam int TRN_DW = 64;
    localparam int TBUF_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PKT  = 2'd1,
        CFG  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/pcie_rr_pick.sv
// Combinational round-robin picker.
//   req   : request vector, one bit per requester
//   ptr   : index searched first; the search wraps past NUM_REQ-1 to 0
//   idx   : first requester with its bit set, at or after ptr
//   found : high when any request bit is set
module pcie_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [PTR_W-1:0]   idx,
    output logic               found
);

    // Rotated view of the request vector: slot gi holds requester (ptr+gi) mod NUM_REQ.
    logic [PTR_W-1:0]   cand [NUM_REQ];
    logic [NUM_REQ-1:0] hit;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
        logic [PTR_W:0] sum;
        assign sum       = {1'b0, ptr} + (PTR_W+1)'(gi);
        assign cand[gi]  = (sum >= (PTR_W+1)'(NUM_REQ)) ? PTR_W'(sum - (PTR_W+1)'(NUM_REQ))
                                                          : sum[PTR_W-1:0];
        assign hit[gi]   = req[cand[gi]];
    end

    // Scan from the far end so the lowest rotated offset wins.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (hit[k]) begin
                idx   = cand[k];
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pcie_trn_tx_arbiter.sv
// Shares the endpoint TRN transmit port among NUM_REQ packet sources, one
// whole TLP at a time, round-robin. Also arbitrates the core's config-TLP
// slot (trn_tcfg_req_n/trn_tcfg_gnt_n) so it never splits a user TLP.
// Ports:
//   trn_clk, trn_reset               : clock, asynchronous active-high reset
//   trn_lnk_up_n                     : link up (active low)
//   req_valid/sof/eof/rem/td         : per-requester beat presentation
//   req_ready                        : per-requester beat accepted
//   trn_t*                           : endpoint TX interface (active-low controls)
//   trn_tdst_rdy_n, trn_tbuf_av      : endpoint flow control
//   trn_tcfg_req_n / trn_tcfg_gnt_n  : config TLP slot handshake
//   abort_count                      : saturating count of link-down aborts
//   pkt_count                        : wrapping count of completed TLPs
module pcie_trn_tx_arbiter
    import pcie_trn_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int MIN_TBUF = 2
) (
    input  logic                      trn_clk,
    input  logic                      trn_reset,
    input  logic                      trn_lnk_up_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_sof,
    input  logic [NUM_REQ-1:0]        req_eof,
    input  logic [NUM_REQ-1:0]        req_rem,
    input  logic [TRN_DW*NUM_REQ-1:0] req_td,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [TRN_DW-1:0]         trn_td,
    output logic                      trn_tsof_n,
    output logic                      trn_teof_n,
    output logic                      trn_trem_n,
    output logic                      trn_tsrc_rdy_n,
    output logic                      trn_tsrc_dsc_n,
    output logic                      trn_terrfwd_n,
    output logic                      trn_tstr_n,
    input  logic                      trn_tdst_rdy_n,
    input  logic [TBUF_W-1:0]         trn_tbuf_av,
    input  logic                      trn_tcfg_req_n,
    output logic                      trn_tcfg_gnt_n,
    output logic [7:0]                abort_count,
    output logic [15:0]               pkt_count
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_t       state_reg;
    logic [PTR_W-1:0] gnt_reg;
    logic [PTR_W-1:0] rr_ptr_reg;
    logic [7:0]       abort_count_reg;
    logic [15:0]      pkt_count_reg;

    logic [NUM_REQ-1:0] sof_req;
    logic [PTR_W-1:0]   pick_idx;
    logic               pick_found;
    logic               in_pkt;
    logic               abort;
    logic               beat_ok;
    logic               eof_done;
    logic               start_ok;
    logic [PTR_W-1:0]   next_ptr;

    // Only the first beat of a TLP may win a grant; mid-packet beats are ignored.
    assign sof_req = req_valid & req_sof;

    pcie_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .req   (sof_req),
        .ptr   (rr_ptr_reg),
        .idx   (pick_idx),
        .found (pick_found)
    );

    assign in_pkt   = (state_reg == PKT);
    assign abort    = in_pkt & trn_lnk_up_n;
    // No beat is accepted in the abort cycle, so the source keeps the rest.
    assign beat_ok  = in_pkt & ~trn_lnk_up_n & req_valid[gnt_reg] & ~trn_tdst_rdy_n;
    assign eof_done = beat_ok & req_eof[gnt_reg];
    assign start_ok = ~trn_lnk_up_n & (trn_tbuf_av >= TBUF_W'(MIN_TBUF)) & pick_found;
    assign next_ptr = (gnt_reg == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_reg + 1'b1;

    always_ff @(posedge trn_clk or posedge trn_reset) begin
        if (trn_reset) begin
            state_reg       <= IDLE;
            gnt_reg         <= '0;
            rr_ptr_reg      <= '0;
            abort_count_reg <= '0;
            pkt_count_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    // Config slot takes priority over a user packet.
                    if (!trn_tcfg_req_n) begin
                        state_reg <= CFG;
                    end else if (start_ok) begin
                        state_reg <= PKT;
                        gnt_reg   <= pick_idx;
                    end
                end
                PKT: begin
                    if (abort) begin
                        state_reg  <= IDLE;
                        rr_ptr_reg <= next_ptr;
                        if (abort_count_reg != 8'hFF) begin
                            abort_count_reg <= abort_count_reg + 8'd1;
                        end
                    end else if (eof_done) begin
                        state_reg     <= IDLE;
                        rr_ptr_reg    <= next_ptr;
                        pkt_count_reg <= pkt_count_reg + 16'd1;
                    end
                end
                CFG: begin
                    if (trn_tcfg_req_n) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Endpoint side mirrors the granted requester while a packet is in flight.
    always_comb begin
        req_ready = '0;
        if (beat_ok) begin
            req_ready[gnt_reg] = 1'b1;
        end
    end

    assign trn_td         = in_pkt ? req_td[int'(gnt_reg)*TRN_DW +: TRN_DW] : '0;
    assign trn_tsof_n     = ~(in_pkt & req_sof[gnt_reg]);
    assign trn_teof_n     = ~(in_pkt & req_eof[gnt_reg]);
    assign trn_trem_n     = in_pkt ? (req_eof[gnt_reg] & ~req_rem[gnt_reg]) : 1'b1;
    assign trn_tsrc_rdy_n = ~(in_pkt & req_valid[gnt_reg]);
    assign trn_tsrc_dsc_n = ~abort;
    assign trn_terrfwd_n  = 1'b1;
    assign trn_tstr_n     = 1'b1;
    assign trn_tcfg_gnt_n = ~((state_reg == CFG) & ~trn_tcfg_req_n);

    assign abort_count = abort_count_reg;
    assign pkt_count   = pkt_count_reg;

endmodule
